// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812B NRZ serialiser for frames of 24-bit GRB pixel words
module ws2812_driver #(
    parameter int TOTAL_LEDS   = 1024,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] grb_data,
    output logic        led_busy,
    output logic        led_busy_buffer,
    output logic        dout,
    output logic        frame_done
);

    // One counter serves both the bit timer (0..BIT_CYCLES-1) and the latch timer (0..RESET_CYCLES)
    localparam int CNT_MAX = (BIT_CYCLES - 1 > RESET_CYCLES) ? BIT_CYCLES - 1 : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIX_W   = (TOTAL_LEDS > 1) ? $clog2(TOTAL_LEDS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(RESET_CYCLES);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(TOTAL_LEDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_LATCH
    } state_t;

    state_t           state_q;
    logic [23:0]      shift_q;
    logic [4:0]       bit_idx_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [PIX_W-1:0] pixel_cnt_q;
    logic             dout_q;
    logic             led_busy_q;
    logic             led_busy_buffer_q;
    logic             frame_done_q;

    // Frame sequencer: outputs are registered from the current state, so they trail it by one cycle.
    // The latch phase spends RESET_CYCLES low cycles plus one final cycle that raises frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            shift_q           <= '0;
            bit_idx_q         <= '0;
            cycle_cnt_q       <= '0;
            pixel_cnt_q       <= '0;
            dout_q            <= 1'b0;
            led_busy_q        <= 1'b0;
            led_busy_buffer_q <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            dout_q            <= 1'b0;
            led_busy_q        <= 1'b0;
            frame_done_q      <= 1'b0;
            led_busy_buffer_q <= led_busy_q;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q     <= grb_data;
                    bit_idx_q   <= '0;
                    cycle_cnt_q <= '0;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    led_busy_q <= 1'b1;
                    dout_q     <= (cycle_cnt_q < (shift_q[23] ? T1H_C : T0H_C));
                    if (cycle_cnt_q == BIT_LAST) begin
                        cycle_cnt_q <= '0;
                        shift_q     <= {shift_q[22:0], 1'b0};
                        if (bit_idx_q == 5'd23) begin
                            bit_idx_q <= '0;
                            if (pixel_cnt_q < PIX_LAST) begin
                                pixel_cnt_q <= pixel_cnt_q + PIX_W'(1);
                                state_q     <= S_LOAD;
                            end else begin
                                pixel_cnt_q <= '0;
                                state_q     <= S_LATCH;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 5'd1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (cycle_cnt_q == LATCH_END) begin
                        frame_done_q <= 1'b1;
                        cycle_cnt_q  <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout            = dout_q;
    assign led_busy        = led_busy_q;
    assign led_busy_buffer = led_busy_buffer_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - self-checking bench for ws2812_driver against a per-cycle waveform model
module tb_ws2812_driver;

    localparam int TL = 2;
    localparam int BC = 10;
    localparam int T0 = 3;
    localparam int T1 = 7;
    localparam int RC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] grb_data = 24'h0;
    logic        led_busy;
    logic        led_busy_buffer;
    logic        dout;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    ws2812_driver #(
        .TOTAL_LEDS  (TL),
        .BIT_CYCLES  (BC),
        .T0H_CYCLES  (T0),
        .T1H_CYCLES  (T1),
        .RESET_CYCLES(RC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .grb_data       (grb_data),
        .led_busy       (led_busy),
        .led_busy_buffer(led_busy_buffer),
        .dout           (dout),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: per pixel 24 bits of BC cycles each, high for T1/T0 cycles depending on the bit,
    // one low cycle between pixels, RC low latch cycles, then a single frame_done cycle.
    // Entered on a negedge; exp_gap is the number of low samples expected before led_busy rises.
    task automatic run_frame(input logic [TL-1:0][23:0] px, input logic [23:0] next_val,
                             input int exp_gap, input bit drop_en, input string name);
        int   gap;
        bit   prev_busy;
        bit   first;
        logic [3:0] exp_v;
        gap = 0;
        @(negedge clk);
        while (led_busy !== 1'b1 && gap < 100) begin
            check({name, "_pre_idle"}, 32'({dout, led_busy, frame_done}), 32'(0));
            @(negedge clk);
            gap++;
        end
        if (gap >= 100) begin
            check({name, "_rise_timeout"}, 32'(0), 32'(1));
            return;
        end
        if (exp_gap >= 0) check({name, "_start_gap"}, 32'(gap), 32'(exp_gap));
        prev_busy = 1'b0;
        first = 1'b1;
        for (int p = 0; p < TL; p++) begin
            for (int b = 0; b < 24; b++) begin
                for (int c = 0; c < BC; c++) begin
                    if (!first) @(negedge clk);
                    first = 1'b0;
                    exp_v[3] = (c < (px[p][23-b] ? T1 : T0));
                    exp_v[2] = 1'b1;
                    exp_v[1] = prev_busy;
                    exp_v[0] = 1'b0;
                    check({name, "_send"}, 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(exp_v));
                    prev_busy = 1'b1;
                    if (b == 0 && c == 0) begin
                        // LOAD is already past: changing the word now must not affect this pixel
                        grb_data = (p < TL - 1) ? px[p+1] : next_val;
                        if (p == 0 && drop_en) enable = 1'b0;
                    end
                end
            end
            if (p < TL - 1) begin
                @(negedge clk);
                check({name, "_load_gap"}, 32'({dout, led_busy, led_busy_buffer, frame_done}),
                      32'({1'b0, 1'b0, 1'b1, 1'b0}));
                prev_busy = 1'b0;
            end
        end
        for (int i = 0; i < RC; i++) begin
            @(negedge clk);
            check({name, "_latch"}, 32'({dout, led_busy, led_busy_buffer, frame_done}),
                  32'({1'b0, 1'b0, prev_busy, 1'b0}));
            prev_busy = 1'b0;
        end
        @(negedge clk);
        check({name, "_frame_done"}, 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(4'b0001));
    endtask

    logic [TL-1:0][23:0] f0, f1, f2, fr;
    int n;

    initial begin
        f0[0] = 24'hA50000;
        f0[1] = 24'($urandom);
        f1[0] = 24'($urandom);
        f1[1] = 24'($urandom);
        f2[0] = 24'($urandom);
        f2[1] = 24'($urandom);
        fr[0] = 24'($urandom) | 24'h800000;
        fr[1] = 24'($urandom);

        rst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(0));
        enable = 1'b1;
        grb_data = f0[0];
        @(negedge clk);
        check("reset_hold_enabled", 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(0));
        rst = 1'b1;

        run_frame(f0, f1[0], 2, 1'b0, "frame0");
        run_frame(f1, f2[0], 2, 1'b0, "frame1");
        run_frame(f2, fr[0], 2, 1'b1, "frame2_drop");

        repeat (600) begin
            @(negedge clk);
            check("idle_after_drop", 32'({dout, led_busy, frame_done}), 32'(0));
        end

        // Interrupt a pixel while a '1' bit is high, then restart from pixel 0
        enable = 1'b1;
        n = 0;
        while (!(led_busy === 1'b1 && dout === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midbit_reached", 32'(n < 100), 32'(1));
        repeat (2) @(negedge clk);
        check("midbit_dout_high", 32'(dout), 32'(1));
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(0));
        grb_data = fr[0];
        repeat (3) @(negedge clk);
        check("reset_low_outputs", 32'({dout, led_busy, led_busy_buffer, frame_done}), 32'(0));
        rst = 1'b1;
        run_frame(fr, f0[0], 2, 1'b1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_driver.md
Name: ws2812_driver

Overview:
- Serialises 24-bit GRB pixel words onto a single WS2812B data line using NRZ pulse-width encoding.
- Sits directly downstream of the LED image/palette fetch stage. It consumes that stage's grb_data and produces the led_busy / led_busy_buffer pair that advances the fetch stage's pixel address.
- Runs back-to-back frames of TOTAL_LEDS pixels, each frame followed by a latch/reset low period.

Parameters:
- TOTAL_LEDS, 1024, pixels per frame; must match the fetch stage's address wrap.
- BIT_CYCLES, 125, clk cycles per bit (1.25 us at 100 MHz).
- T0H_CYCLES, 40, high time of a '0' bit (400 ns).
- T1H_CYCLES, 80, high time of a '1' bit (800 ns).
- RESET_CYCLES, 30000, low latch time after a frame (300 us; WS2812B requires at least 280 us).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-low.
- enable  input  1  level; permits starting a new frame.
- grb_data  input  24  pixel word from the fetch stage, {G,R,B}.
- led_busy  output  1  high while a pixel's 24 bits are being sent.
- led_busy_buffer  output  1  led_busy registered one cycle; the fetch stage uses it for edge detection.
- dout  output  1  serial data line to the LED strip.
- frame_done  output  1  one-cycle pulse at the end of each latch period.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dout=0, led_busy=0, led_busy_buffer=0, frame_done=0; pixel counter, bit counter, cycle counter and shift register all 0.
- All outputs are registered.
- States: IDLE, LOAD, SEND, LATCH.
- IDLE: dout=0, led_busy=0. If enable=1, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - led_busy=0, dout=0.
  - shift_reg <= grb_data.
  - bit_idx <= 0, cycle_cnt <= 0.
  - Go to SEND.
- SEND:
  - led_busy=1 every cycle. The 0->1 transition on entry from LOAD is the fetch stage's increment event.
  - dout=1 while cycle_cnt < (shift_reg[23] ? T1H_CYCLES : T0H_CYCLES), else dout=0.
  - cycle_cnt counts 0..BIT_CYCLES-1. At BIT_CYCLES-1: shift_reg shifts left by 1 (MSB first: G7 first, B0 last), bit_idx increments, cycle_cnt wraps to 0.
  - After bit_idx 23 completes:
    - if pixel_cnt < TOTAL_LEDS-1: pixel_cnt++ and go to LOAD;
    - otherwise pixel_cnt <= 0 and go to LATCH.
- The LOAD cycle between pixels inserts exactly one extra low cycle on dout. This guarantees led_busy drops for at least one cycle per pixel.
- Pixel period is 24*BIT_CYCLES+1 cycles.
- grb_data only needs to be stable in the LOAD cycle. The fetch stage's 4-cycle BRAM latency is covered by the preceding pixel period.
- LATCH: dout=0, led_busy=0 for exactly RESET_CYCLES cycles. Then frame_done pulses for 1 cycle and the state goes to IDLE. If enable is still 1, LOAD follows on the next cycle.
- enable is sampled only in IDLE. Dropping enable mid-frame does not truncate the frame; the frame and its latch period complete.
- Width rules:
  - counters sized with $clog2 of max+1;
  - T1H_CYCLES > T0H_CYCLES, and T1H_CYCLES < BIT_CYCLES.
- Reset asserted mid-bit: dout goes to 0 immediately (asynchronously). The frame restarts from pixel 0 once reset is released and enable=1.
- The fetch stage's counter must share the same reset.

Test Plan:
- Params TOTAL_LEDS=2, BIT_CYCLES=10, T0H_CYCLES=3, T1H_CYCLES=7, RESET_CYCLES=20; grb_data=24'hA50000, enable=1.
  -> First bit: dout high 7 cycles, low 3. Second bit: high 3, low 7. Bit pattern 1010_0101 then 16 zeros.
- Same params -> led_busy high for 240 consecutive cycles per pixel, with exactly 1 low cycle between pixel 0 and pixel 1. led_busy_buffer equals led_busy delayed 1 cycle.
- Same params, grb_data changed 1 cycle after the LOAD cycle -> transmitted bits reflect the old value; the new value is used at the next LOAD.
- After pixel 1's last bit -> dout=0 and led_busy=0 for 20 cycles, frame_done high for exactly 1 cycle, then the next LOAD (enable=1). Frame-to-frame period is 504 cycles.
- enable deasserted during pixel 0 -> both pixels and the latch period complete, frame_done pulses, then the block stays in IDLE with dout=0 indefinitely.
- rst=0 pulsed mid-bit while dout=1 -> dout=0 in the same cycle without waiting for a clk edge, all outputs 0. After release with enable=1, transmission restarts at pixel 0, bit 0.
